// File: rtl/axil_pkg.sv
// Shared AXI-Lite types for the read/write routers: response codes, router FSM states,
// and the sizing helper for the slave select index.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    ERR  = 2'b11
  } rd_state_t;

  // A single-slave router still needs a 1-bit select so that every port has a legal width.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_addr_match.sv
// Combinational region decoder: priority-encodes the lowest-index slave whose region holds addr,
// or flags the address as illegal when no region does.
module axil_addr_match
  import axil_pkg::*;
#(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = '0,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  =
    {NUMBER_SLAVE{AXI_ADDR_WIDTH'(1)}},
  localparam int SEL_W = sel_width(NUMBER_SLAVE)
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [SEL_W-1:0]          sel,
  output logic                      illegal
);

  logic [AXI_ADDR_WIDTH:0] addr_ext;
  logic [AXI_ADDR_WIDTH:0] lo;
  logic [AXI_ADDR_WIDTH:0] hi;

  assign addr_ext = {1'b0, addr};

  // One extra bit lets a region end exactly at 2^W; scanning downwards makes the lowest index win.
  always_comb begin
    sel     = '0;
    illegal = 1'b1;
    lo      = '0;
    hi      = '0;
    for (int i = NUMBER_SLAVE - 1; i >= 0; i--) begin
      lo = {1'b0, AXI_ADDR_OFFSET[i]};
      hi = lo + {1'b0, AXI_ADDR_RANGE[i]};
      if ((addr_ext >= lo) && (addr_ext < hi)) begin
        sel     = SEL_W'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_router_rd.sv
// AXI-Lite read router: one master, NUMBER_SLAVE slaves, a single outstanding read.
// Handshakes are standard valid/ready: a beat transfers on a rising edge where both are high.
module axil_router_rd
  import axil_pkg::*;
#(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = '0,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  =
    {NUMBER_SLAVE{AXI_ADDR_WIDTH'(1)}}
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [AXI_ADDR_WIDTH-1:0]              s_araddr,
  input  logic [2:0]                             s_arprot,
  input  logic                                   s_arvalid,
  output logic                                   s_arready,
  output logic [AXI_DATA_WIDTH-1:0]              s_rdata,
  output logic [1:0]                             s_rresp,
  output logic                                   s_rvalid,
  input  logic                                   s_rready,
  output logic [AXI_ADDR_WIDTH-1:0]              m_araddr,
  output logic [2:0]                             m_arprot,
  output logic [NUMBER_SLAVE-1:0]                m_arvalid,
  input  logic [NUMBER_SLAVE-1:0]                m_arready,
  input  logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0] m_rdata,
  input  logic [NUMBER_SLAVE*2-1:0]              m_rresp,
  input  logic [NUMBER_SLAVE-1:0]                m_rvalid,
  output logic [NUMBER_SLAVE-1:0]                m_rready
);

  localparam int SEL_W = sel_width(NUMBER_SLAVE);

  rd_state_t                   state_q, state_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [2:0]                  arprot_q, arprot_d;
  logic [NUMBER_SLAVE-1:0]     m_arvalid_q, m_arvalid_d;
  logic                        s_arready_q, s_arready_d;
  logic [SEL_W-1:0]            match_sel;
  logic                        match_illegal;

  axil_addr_match #(
    .NUMBER_SLAVE    (NUMBER_SLAVE),
    .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
    .AXI_ADDR_OFFSET (AXI_ADDR_OFFSET),
    .AXI_ADDR_RANGE  (AXI_ADDR_RANGE)
  ) u_addr_match (
    .addr    (s_araddr),
    .sel     (match_sel),
    .illegal (match_illegal)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    m_arvalid_d = m_arvalid_q;
    s_arready_d = s_arready_q;
    case (state_q)
      IDLE: begin
        if (s_arvalid && s_arready_q) begin
          araddr_d    = s_araddr;
          arprot_d    = s_arprot;
          sel_d       = match_sel;
          s_arready_d = 1'b0;
          if (match_illegal) begin
            state_d = ERR;
          end else begin
            state_d = ADDR;
            for (int i = 0; i < NUMBER_SLAVE; i++) begin
              m_arvalid_d[i] = (match_sel == SEL_W'(i));
            end
          end
        end
      end
      ADDR: begin
        if (m_arready[sel_q]) begin
          m_arvalid_d = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (m_rvalid[sel_q] && s_rready) begin
          state_d     = IDLE;
          s_arready_d = 1'b1;
        end
      end
      ERR: begin
        if (s_rready) begin
          state_d     = IDLE;
          s_arready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        m_arvalid_d = '0;
        s_arready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      m_arvalid_q <= '0;
      s_arready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
      m_arvalid_q <= m_arvalid_d;
      s_arready_q <= s_arready_d;
    end
  end

  assign s_arready = s_arready_q;
  assign m_araddr  = araddr_q;
  assign m_arprot  = arprot_q;
  assign m_arvalid = m_arvalid_q;

  // The R channel is a zero-latency mux of the selected slave; other slaves never see rready.
  always_comb begin
    s_rvalid = 1'b0;
    s_rdata  = '0;
    s_rresp  = OKAY;
    m_rready = '0;
    case (state_q)
      DATA: begin
        s_rvalid        = m_rvalid[sel_q];
        s_rdata         = m_rdata[sel_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        s_rresp         = m_rresp[sel_q*2 +: 2];
        m_rready[sel_q] = s_rready;
      end
      ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = DECERR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_router_rd.sv
// Directed + randomized bench for axil_router_rd with a region-lookup reference model.
module tb_axil_router_rd;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [NS-1:0][AW-1:0] OFF    = {32'hFFFF_F000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS-1:0][AW-1:0] RNG    = {32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_1000};
  localparam logic [NS-1:0][AW-1:0] RNG_OV = {32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};

  logic aclk = 1'b0;
  logic areset;

  logic [AW-1:0]    s_araddr;
  logic [2:0]       s_arprot;
  logic             s_arvalid, s_arready;
  logic [DW-1:0]    s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rvalid, s_rready;
  logic [AW-1:0]    m_araddr;
  logic [2:0]       m_arprot;
  logic [NS-1:0]    m_arvalid, m_arready;
  logic [NS*DW-1:0] m_rdata;
  logic [NS*2-1:0]  m_rresp;
  logic [NS-1:0]    m_rvalid, m_rready;

  logic [AW-1:0]    o_s_araddr;
  logic [2:0]       o_s_arprot;
  logic             o_s_arvalid, o_s_arready;
  logic [DW-1:0]    o_s_rdata;
  logic [1:0]       o_s_rresp;
  logic             o_s_rvalid, o_s_rready;
  logic [AW-1:0]    o_m_araddr;
  logic [2:0]       o_m_arprot;
  logic [NS-1:0]    o_m_arvalid, o_m_arready;
  logic [NS*DW-1:0] o_m_rdata;
  logic [NS*2-1:0]  o_m_rresp;
  logic [NS-1:0]    o_m_rvalid, o_m_rready;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW+1:0] exp_q[$];

  // clock / reset
  always #5 aclk = ~aclk;

  axil_router_rd #(
    .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_OFFSET(OFF), .AXI_ADDR_RANGE(RNG)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  axil_router_rd #(
    .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_OFFSET(OFF), .AXI_ADDR_RANGE(RNG_OV)
  ) dut_ov (
    .aclk(aclk), .areset(areset),
    .s_araddr(o_s_araddr), .s_arprot(o_s_arprot), .s_arvalid(o_s_arvalid), .s_arready(o_s_arready),
    .s_rdata(o_s_rdata), .s_rresp(o_s_rresp), .s_rvalid(o_s_rvalid), .s_rready(o_s_rready),
    .m_araddr(o_m_araddr), .m_arprot(o_m_arprot), .m_arvalid(o_m_arvalid), .m_arready(o_m_arready),
    .m_rdata(o_m_rdata), .m_rresp(o_m_rresp), .m_rvalid(o_m_rvalid), .m_rready(o_m_rready)
  );

  // Reference: first region (lowest index) containing the address, computed in 64-bit arithmetic.
  function automatic int ref_slave(input longint a, input bit ov);
    longint offs[4] = '{64'h0, 64'h1000, 64'h2000, 64'hFFFF_F000};
    longint rngs[4] = '{64'h1000, 64'h1000, 64'h2000, 64'h1000};
    if (ov) rngs[0] = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      if (a >= offs[i] && a < offs[i] + rngs[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one full read through the main DUT, with the bench acting as all slaves
  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] d, input bit slverr,
                         input int ar_stall, input int r_wait, input int rr_stall);
    int idx, sp;
    logic [2:0] prot;
    logic [DW+1:0] exp;
    idx  = ref_slave(longint'(addr), 1'b0);
    prot = 3'($urandom_range(0, 7));
    #1 check("idle_arready", {63'd0, s_arready}, 64'd1);
    s_araddr  = addr;
    s_arprot  = prot;
    s_arvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    s_arvalid = 1'b0;
    s_araddr  = $urandom;
    #1;
    check("busy_arready", {63'd0, s_arready}, 64'd0);
    if (idx < 0) begin
      check("err_arvalid", {60'd0, m_arvalid}, 64'd0);
      check("err_rvalid", {63'd0, s_rvalid}, 64'd1);
      check("err_rresp", {62'd0, s_rresp}, 64'd3);
      check("err_rdata", {32'd0, s_rdata}, 64'd0);
      for (int k = 0; k < r_wait; k++) begin
        @(negedge aclk); #1;
        check("err_hold_rvalid", {63'd0, s_rvalid}, 64'd1);
        check("err_hold_rresp", {62'd0, s_rresp}, 64'd3);
        check("err_hold_rdata", {32'd0, s_rdata}, 64'd0);
      end
      s_rready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      s_rready = 1'b0;
    end else begin
      check("ar_onehot", {60'd0, m_arvalid}, 64'd1 << idx);
      check("ar_addr", {32'd0, m_araddr}, {32'd0, addr});
      check("ar_prot", {61'd0, m_arprot}, {61'd0, prot});
      check("ar_no_rvalid", {63'd0, s_rvalid}, 64'd0);
      for (int k = 0; k < ar_stall; k++) begin
        @(negedge aclk); #1;
        check("ar_stall_valid", {60'd0, m_arvalid}, 64'd1 << idx);
        check("ar_stall_addr", {32'd0, m_araddr}, {32'd0, addr});
      end
      m_arready[idx] = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      m_arready = '0;
      #1 check("ar_done", {60'd0, m_arvalid}, 64'd0);
      // an unselected slave shouts a beat throughout the data phase
      sp = (idx + 1) % NS;
      m_rvalid[sp] = 1'b1;
      m_rdata[sp*DW +: DW] = ~d;
      m_rresp[sp*2 +: 2] = 2'b01;
      for (int k = 0; k < r_wait; k++) begin
        s_rready = 1'($urandom_range(0, 1));
        #1;
        check("r_wait_rvalid", {63'd0, s_rvalid}, 64'd0);
        check("r_wait_rready", {60'd0, m_rready}, {63'd0, s_rready} << idx);
        @(negedge aclk);
      end
      exp_q.push_back({slverr ? 2'b10 : 2'b00, d});
      m_rvalid[idx] = 1'b1;
      m_rdata[idx*DW +: DW] = d;
      m_rresp[idx*2 +: 2] = slverr ? 2'b10 : 2'b00;
      s_rready = 1'b0;
      for (int k = 0; k < rr_stall; k++) begin
        #1;
        check("r_stall_rvalid", {63'd0, s_rvalid}, 64'd1);
        check("r_stall_rready", {60'd0, m_rready}, 64'd0);
        @(negedge aclk);
      end
      s_rready = 1'b1;
      #1;
      exp = exp_q.pop_front();
      check("r_rvalid", {63'd0, s_rvalid}, 64'd1);
      check("r_rready", {60'd0, m_rready}, 64'd1 << idx);
      check("r_beat", {30'd0, s_rresp, s_rdata}, {30'd0, exp});
      @(posedge aclk);
      @(negedge aclk);
      s_rready = 1'b0;
      m_rvalid = '0;
    end
    #1;
    check("post_arready", {63'd0, s_arready}, 64'd1);
    check("post_rvalid", {63'd0, s_rvalid}, 64'd0);
  endtask

  initial begin
    int r;
    logic [AW-1:0] a;
    areset = 1'b1;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
    o_s_araddr = '0; o_s_arprot = '0; o_s_arvalid = 1'b0; o_s_rready = 1'b0;
    o_m_arready = '0; o_m_rdata = '0; o_m_rresp = '0; o_m_rvalid = '0;
    repeat (2) @(negedge aclk);
    #1;
    check("rst_arready", {63'd0, s_arready}, 64'd1);
    check("rst_rvalid", {63'd0, s_rvalid}, 64'd0);
    check("rst_rresp", {62'd0, s_rresp}, 64'd0);
    check("rst_rdata", {32'd0, s_rdata}, 64'd0);
    check("rst_arvalid", {60'd0, m_arvalid}, 64'd0);
    check("rst_rready", {60'd0, m_rready}, 64'd0);
    check("rst_araddr", {32'd0, m_araddr}, 64'd0);
    check("rst_arprot", {61'd0, m_arprot}, 64'd0);
    @(negedge aclk);
    areset = 1'b0;

    // directed reads
    do_read(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    do_read(32'h0000_5000, 32'h0, 1'b0, 0, 5, 0);
    do_read(32'hFFFF_FFFC, 32'h1111_2222, 1'b1, 1, 1, 2);
    do_read(32'h0000_0FFF, 32'h3333_4444, 1'b0, 2, 2, 1);
    do_read(32'h0000_1000, 32'h5555_6666, 1'b0, 0, 3, 0);
    do_read(32'h0000_3FFF, 32'h7777_8888, 1'b1, 0, 0, 1);
    do_read(32'h0000_4000, 32'h0, 1'b0, 0, 1, 0);
    do_read(32'hFFFF_EFFF, 32'h0, 1'b0, 0, 0, 0);

    // overlapping regions on the second instance: slave 0 covers 0x1800 ahead of slave 1
    o_s_araddr = 32'h0000_1800;
    o_s_arvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    o_s_arvalid = 1'b0;
    o_s_araddr = 32'hA5A5_A5A5;
    #1;
    r = ref_slave(64'h1800, 1'b1);
    check("ov_onehot", {60'd0, o_m_arvalid}, 64'd1 << r);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk); #1;
      check("ov_stall_addr", {32'd0, o_m_araddr}, 64'h1800);
      check("ov_stall_valid", {60'd0, o_m_arvalid}, 64'd1 << r);
    end
    o_m_arready[0] = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    o_m_arready = '0;
    o_m_rvalid[0] = 1'b1;
    o_m_rdata[DW-1:0] = 32'hC0FF_EE00;
    o_s_rready = 1'b1;
    #1;
    check("ov_rdata", {32'd0, o_s_rdata}, 64'hC0FF_EE00);
    check("ov_rready", {60'd0, o_m_rready}, 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    o_m_rvalid = '0;
    o_s_rready = 1'b0;
    #1 check("ov_post_arready", {63'd0, o_s_arready}, 64'd1);

    // reset pulsed while a read to slave 1 sits in its data phase
    @(negedge aclk);
    s_araddr = 32'h0000_1008;
    s_arvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    s_arvalid = 1'b0;
    m_arready[1] = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    m_arready = '0;
    m_rvalid[1] = 1'b1;
    m_rdata[DW +: DW] = 32'h1234_5678;
    s_rready = 1'b0;
    #1 check("pre_rst_rvalid", {63'd0, s_rvalid}, 64'd1);
    areset = 1'b1;
    #1;
    check("mid_rst_arready", {63'd0, s_arready}, 64'd1);
    check("mid_rst_rvalid", {63'd0, s_rvalid}, 64'd0);
    check("mid_rst_rdata", {32'd0, s_rdata}, 64'd0);
    check("mid_rst_rready", {60'd0, m_rready}, 64'd0);
    check("mid_rst_araddr", {32'd0, m_araddr}, 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    m_rvalid = '0;
    @(negedge aclk);
    do_read(32'h0000_2010, 32'h0BAD_F00D, 1'b0, 1, 0, 1);

    // randomized reads over mapped, unmapped and top-of-space addresses
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0: a = 32'($urandom_range(0, 32'h5FFF));
        1: a = 32'hFFFF_F000 + 32'($urandom_range(0, 32'hFFF));
        default: a = $urandom;
      endcase
      do_read(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // report
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
